// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sliced sequential adder: FSM encoding and a
// constant-evaluable ceiling log2 used to size the slice counter.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_adder_slice.sv
// Combinational SLICE-bit ripple of full adders; also exposes the carry into
// the top cell so the caller can derive signed overflow.
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  logic [SLICE:0] c;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = cin_i;
    for (int i = 0; i < SLICE; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o     = c[SLICE];
  assign c_msb_in_o = c[SLICE-1];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit chunk per clock, carry held in a
// register between chunks, start/busy/done handshake toward the sequencer.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             carry_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? clog2(NSLICE) : 1;

  if ((SLICE < 1) || (SLICE > WIDTH) || (WIDTH % SLICE != 0)) begin : g_bad_param
    $error("seq_adder: SLICE must be in 1..WIDTH and divide WIDTH");
  end

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   sum_d;
  logic               cout_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic [SLICE-1:0]       slice_s;
  logic                   slice_cout;
  logic                   slice_cmsb;
  logic [WIDTH+SLICE-1:0] sum_ext;

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a_i        (a_q[SLICE-1:0]),
    .b_i        (b_q[SLICE-1:0]),
    .cin_i      (carry_q),
    .s_o        (slice_s),
    .cout_o     (slice_cout),
    .c_msb_in_o (slice_cmsb)
  );

  // New slice enters from the top; after NSLICE shifts slice 0 sits at bit 0.
  assign sum_ext = {slice_s, sum_q} >> SLICE;
  assign sum_d   = sum_ext[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= input1;
            b_q     <= sub ? ~input2 : input2;
            carry_q <= sub | carry_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NSLICE - 1)) begin
            cout_q  <= slice_cout;
            ovf_q   <= slice_cout ^ slice_cmsb;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: 16/4 main instance plus 4/1 and 4/4 instances
// swept over every (A, B, cin) combination.
module tb_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] input1;
  logic [15:0] input2;
  logic        carry_in;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  logic        start_s;
  logic [3:0]  a_s;
  logic [3:0]  b_s;
  logic        cin_s;
  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  sum1;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  int checks   = 0;
  int failures = 0;

  logic [17:0] sb_q[$];   // {overflow, carry_out, sum}
  logic [4:0]  sb_s[$];   // {carry_out, sum}

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .input1(input1), .input2(input2),
    .carry_in(carry_in), .sub(sub), .busy(busy), .done(done), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  seq_adder #(.WIDTH(4), .SLICE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start_s), .input1(a_s), .input2(b_s),
    .carry_in(cin_s), .sub(1'b0), .busy(busy1), .done(done1), .sum(sum1),
    .carry_out(cout1), .overflow(ovf1)
  );

  seq_adder #(.WIDTH(4), .SLICE(4)) u_dut_s4 (
    .clk(clk), .rst(rst), .start(start_s), .input1(a_s), .input2(b_s),
    .carry_in(cin_s), .sub(1'b0), .busy(busy4), .done(done4), .sum(sum4),
    .carry_out(cout4), .overflow(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-width reference: {overflow, carry_out, sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    logic [15:0] bb;
    logic [16:0] r;
    logic        v;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : ci)};
    v  = (a[15] == bb[15]) && (r[15] != a[15]);
    return {v, r};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic op(input string name, input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic s, input logic flood,
                    input logic [17:0] exp);
    int          lat;
    int          busy_low;
    logic [17:0] e;
    input1 = a; input2 = b; carry_in = ci; sub = s; start = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    start    = flood;
    lat      = 1;
    busy_low = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_low++;
      if (flood) begin
        input1   = 16'($urandom);
        input2   = 16'($urandom);
        carry_in = 1'($urandom);
        sub      = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'd5);
    check({name, "_busy_run"}, 32'(busy_low), 32'd0);
    check({name, "_busy_at_done"}, 32'(busy), 32'd1);
    e = sb_q.pop_front();
    check({name, "_sum"}, 32'(sum), 32'(e[15:0]));
    check({name, "_carry_out"}, 32'(carry_out), 32'(e[16]));
    check({name, "_overflow"}, 32'(overflow), 32'(e[17]));
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic small_op(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic       got1, got4;
    logic [4:0] r1, r4, e;
    a_s = a; b_s = b; cin_s = ci; start_s = 1'b1;
    sb_s.push_back(5'({1'b0, a} + {1'b0, b} + {4'd0, ci}));
    @(negedge clk);
    start_s = 1'b0;
    got1 = 1'b0; got4 = 1'b0; r1 = '0; r4 = '0;
    for (int lat = 1; lat < 20 && !(got1 && got4); lat++) begin
      if (done1) begin got1 = 1'b1; r1 = {cout1, sum1}; end
      if (done4) begin got4 = 1'b1; r4 = {cout4, sum4}; end
      if (!(got1 && got4)) @(negedge clk);
    end
    @(negedge clk);
    e = sb_s.pop_front();
    check($sformatf("ex_s1_%h_%h_%b", a, b, ci), 32'({got1, r1}), 32'({1'b1, e}));
    check($sformatf("ex_s4_%h_%h_%b", a, b, ci), 32'({got4, r4}), 32'({1'b1, e}));
  endtask

  initial begin
    int          n;
    logic [15:0] ra, rb;
    logic        rc, rs;
    rst = 1'b1; start = 1'b0; input1 = '0; input2 = '0; carry_in = 1'b0; sub = 1'b0;
    start_s = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op("zero",     16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0000});
    op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    op("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5556});
    op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, {1'b0, 1'b0, 16'hFFFE});
    op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, {1'b1, 1'b1, 16'h7FFF});

    // start held and operands churned during the whole operation
    op("flood",    16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 16'h1000});
    n = 0;
    for (int i = 0; i < 8; i++) begin
      input1 = 16'($urandom); input2 = 16'($urandom);
      if (done) n++;
      @(negedge clk);
    end
    check("flood_extra_done", 32'(n), 32'd0);
    check("flood_sum_hold", 32'(sum), 32'h1000);

    // reset two cycles into RUN
    input1 = 16'h1234; input2 = 16'h4321; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry_out), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) n++;
      @(negedge clk);
    end
    check("midrst_quiet", 32'(n), 32'd0);
    op("after_rst", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});

    // rst and start in the same cycle
    rst = 1'b1; start = 1'b1; input1 = 16'h0001; input2 = 16'h0001;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) n++;
      @(negedge clk);
    end
    check("rst_start_dropped", 32'(n), 32'd0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      op($sformatf("rand%0d", i), ra, rb, rc, rs, 1'b0, model(ra, rb, rc, rs));
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          small_op(4'(a), 4'(b), 1'(c));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "time limit");
  end

endmodule
